// File: rtl/cache_lru_scheduler_pkg.sv
// Shared defaults and width helper for the cache_lru scheduler slice.
package cache_lru_scheduler_pkg;

   localparam int unsigned DEF_NUM_SETS        = 64;
   localparam int unsigned DEF_NUM_WAYS        = 4;
   localparam int unsigned DEF_NUM_REQUESTERS  = 4;
   localparam int unsigned DEF_FILL_FIFO_DEPTH = 4;
   localparam int unsigned DEF_STARVE_LIMIT    = 8;

   // Index width that never collapses to zero bits (NUM_WAYS may be 1).
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cache_lru_scheduler_if.sv
// Fill, access and cache_lru port bundle between the L1 tag/fill path and the scheduler.
interface cache_lru_scheduler_if
   import cache_lru_scheduler_pkg::*;
#(
   parameter int unsigned NUM_SETS       = DEF_NUM_SETS,
   parameter int unsigned NUM_WAYS       = DEF_NUM_WAYS,
   parameter int unsigned NUM_REQUESTERS = DEF_NUM_REQUESTERS
);

   localparam int unsigned SET_W = idx_width(NUM_SETS);
   localparam int unsigned WAY_W = idx_width(NUM_WAYS);

   logic                                        fill_req_valid;
   logic [SET_W-1:0]                            fill_req_set;
   logic                                        fill_req_ready;
   logic                                        fill_rsp_valid;
   logic [SET_W-1:0]                            fill_rsp_set;
   logic [WAY_W-1:0]                            fill_rsp_way;
   logic [NUM_REQUESTERS-1:0]                   access_req;
   logic [NUM_REQUESTERS-1:0][SET_W-1:0]        access_req_set;
   logic [NUM_REQUESTERS-1:0]                   access_grant;
   logic [NUM_REQUESTERS-1:0]                   access_hit_en;
   logic [NUM_REQUESTERS-1:0][WAY_W-1:0]        access_hit_way;
   logic                                        lru_fill_en;
   logic [SET_W-1:0]                            lru_fill_set;
   logic [WAY_W-1:0]                            lru_fill_way;
   logic                                        lru_access_en;
   logic [SET_W-1:0]                            lru_access_set;
   logic                                        lru_access_update_en;
   logic [WAY_W-1:0]                            lru_access_update_way;

   modport master (
      output fill_req_valid, fill_req_set, access_req, access_req_set,
             access_hit_en, access_hit_way, lru_fill_way,
      input  fill_req_ready, fill_rsp_valid, fill_rsp_set, fill_rsp_way,
             access_grant, lru_fill_en, lru_fill_set, lru_access_en,
             lru_access_set, lru_access_update_en, lru_access_update_way
   );

   modport slave (
      input  fill_req_valid, fill_req_set, access_req, access_req_set,
             access_hit_en, access_hit_way, lru_fill_way,
      output fill_req_ready, fill_rsp_valid, fill_rsp_set, fill_rsp_way,
             access_grant, lru_fill_en, lru_fill_set, lru_access_en,
             lru_access_set, lru_access_update_en, lru_access_update_way
   );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant from ptr_q; pointer advances past winner on update_i.
module rr_arbiter #(
   parameter int unsigned N = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N-1:0]         req_i,
   input  logic                 update_i,
   output logic [N-1:0]         grant_o,
   output logic [$clog2(N)-1:0] grant_idx_o
);

   localparam int unsigned IW = $clog2(N);

   logic [IW-1:0] ptr_q;
   logic [IW-1:0] idx;
   logic          found;

   always_comb begin
      grant_o     = '0;
      grant_idx_o = '0;
      found       = 1'b0;
      idx         = '0;
      for (int unsigned i = 0; i < N; i++) begin
         idx = ptr_q + IW'(i);
         if (!found && req_i[idx]) begin
            found        = 1'b1;
            grant_o[idx] = 1'b1;
            grant_idx_o  = idx;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_q <= '0;
      end else if (update_i && (|req_i)) begin
         ptr_q <= grant_idx_o + IW'(1);
      end
   end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO; power-of-two depth, wrap-bit pointers, head visible on data_o.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0]      wr_q, rd_q;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             push_en, pop_en;

   assign empty_o = (wr_q == rd_q);
   assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign data_o  = mem_q[rd_q[AW-1:0]];
   assign push_en = push_i && !full_o;
   assign pop_en  = pop_i && !empty_o;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (push_en) wr_q <= wr_q + (AW+1)'(1);
         if (pop_en)  rd_q <= rd_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push_en) mem_q[wr_q[AW-1:0]] <= data_i;
   end

endmodule

// File: rtl/cache_lru_scheduler.sv
// Time-shares one cache_lru between queued line fills and round-robin tag-lookup requesters;
// fills win unless an access has already waited STARVE_LIMIT fill issues.
module cache_lru_scheduler
   import cache_lru_scheduler_pkg::*;
#(
   parameter int unsigned NUM_SETS        = DEF_NUM_SETS,
   parameter int unsigned NUM_WAYS        = DEF_NUM_WAYS,
   parameter int unsigned NUM_REQUESTERS  = DEF_NUM_REQUESTERS,
   parameter int unsigned FILL_FIFO_DEPTH = DEF_FILL_FIFO_DEPTH,
   parameter int unsigned STARVE_LIMIT    = DEF_STARVE_LIMIT
) (
   input  logic                 clk,
   input  logic                 reset,
   cache_lru_scheduler_if.slave bus
);

   localparam int unsigned SET_W    = idx_width(NUM_SETS);
   localparam int unsigned REQ_W    = $clog2(NUM_REQUESTERS);
   localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

   logic                      fifo_full, fifo_empty, fifo_push;
   logic [SET_W-1:0]          fifo_head;
   logic                      access_pending, issue_fill, issue_access;
   logic [NUM_REQUESTERS-1:0] arb_grant;
   logic [REQ_W-1:0]          arb_idx;
   logic [STARVE_W-1:0]       starve_q, starve_d;
   logic                      was_fill_q, was_access_q;
   logic [SET_W-1:0]          rsp_set_q;
   logic [REQ_W-1:0]          gnt_idx_q;

   assign fifo_push      = bus.fill_req_valid && !fifo_full;
   assign access_pending = |bus.access_req;
   assign issue_fill     = !fifo_empty &&
                           (!access_pending || (starve_q < STARVE_W'(STARVE_LIMIT)));
   assign issue_access   = !issue_fill && access_pending;

   sync_fifo #(
      .WIDTH (SET_W),
      .DEPTH (FILL_FIFO_DEPTH)
   ) u_fill_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (fifo_push),
      .data_i  (bus.fill_req_set),
      .pop_i   (issue_fill),
      .data_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Pointer only moves when the access path actually wins the cycle.
   rr_arbiter #(
      .N (NUM_REQUESTERS)
   ) u_arb (
      .clk         (clk),
      .reset       (reset),
      .req_i       (bus.access_req),
      .update_i    (issue_access),
      .grant_o     (arb_grant),
      .grant_idx_o (arb_idx)
   );

   always_comb begin
      starve_d = starve_q;
      if (!access_pending || issue_access) begin
         starve_d = '0;
      end else if (issue_fill && (starve_q < STARVE_W'(STARVE_LIMIT))) begin
         starve_d = starve_q + STARVE_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         starve_q     <= '0;
         was_fill_q   <= 1'b0;
         was_access_q <= 1'b0;
         rsp_set_q    <= '0;
         gnt_idx_q    <= '0;
      end else begin
         starve_q     <= starve_d;
         was_fill_q   <= issue_fill;
         was_access_q <= issue_access;
         rsp_set_q    <= fifo_head;
         gnt_idx_q    <= arb_idx;
      end
   end

   assign bus.fill_req_ready = !fifo_full;
   assign bus.lru_fill_en    = issue_fill;
   assign bus.lru_fill_set   = fifo_head;
   assign bus.lru_access_en  = issue_access;
   assign bus.lru_access_set = bus.access_req_set[arb_idx];
   assign bus.access_grant   = issue_access ? arb_grant : '0;

   // cache_lru returns the victim way one cycle after lru_fill_en; forwarded unregistered.
   assign bus.fill_rsp_valid        = was_fill_q;
   assign bus.fill_rsp_set          = rsp_set_q;
   assign bus.fill_rsp_way          = bus.lru_fill_way;
   assign bus.lru_access_update_en  = was_access_q && bus.access_hit_en[gnt_idx_q];
   assign bus.lru_access_update_way = bus.access_hit_way[gnt_idx_q];

   a_fill_access_exclusive: assert property (
      @(posedge clk) disable iff (reset) !(bus.lru_fill_en && bus.lru_access_en)
   );

endmodule

// File: tb/tb_cache_lru_scheduler.sv
// Scoreboard bench for cache_lru_scheduler: fill order/latency, round-robin grants, starvation bound, reset.
module tb_cache_lru_scheduler;

   localparam int unsigned SETS  = 64;
   localparam int unsigned WAYS  = 4;
   localparam int unsigned REQS  = 4;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned LIMIT = 8;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   cache_lru_scheduler_if #(
      .NUM_SETS       (SETS),
      .NUM_WAYS       (WAYS),
      .NUM_REQUESTERS (REQS)
   ) bus ();

   cache_lru_scheduler #(
      .NUM_SETS        (SETS),
      .NUM_WAYS        (WAYS),
      .NUM_REQUESTERS  (REQS),
      .FILL_FIFO_DEPTH (DEPTH),
      .STARVE_LIMIT    (LIMIT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Stand-in for cache_lru: victim way is a fixed function of the filled set.
   function automatic logic [1:0] way_of(input logic [5:0] s);
      return s[1:0] ^ 2'b11;
   endfunction

   always @(posedge clk) bus.lru_fill_way <= way_of(bus.lru_fill_set);

   typedef struct packed {
      logic [5:0] set;
      logic [1:0] way;
   } rsp_t;

   int   n_checks = 0;
   int   n_pass   = 0;
   logic [5:0] exp_issue_q[$];
   rsp_t       exp_rsp_q[$];
   int         exp_gnt_q[$];
   int   occ;
   bit   rsp_due, prev_gnt, starve_mode, saw_full;
   int   prev_idx, fill_run, grants_seen;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic idle_inputs();
      bus.fill_req_valid = 1'b0;
      bus.fill_req_set   = '0;
      bus.access_req     = '0;
      bus.access_req_set = '0;
      bus.access_hit_en  = '0;
      bus.access_hit_way = '0;
   endtask

   task automatic flush_model();
      exp_issue_q.delete();
      exp_rsp_q.delete();
      exp_gnt_q.delete();
      occ = 0; rsp_due = 0; prev_gnt = 0; prev_idx = 0; fill_run = 0;
   endtask

   // Called at a falling edge with inputs already driven for this cycle.
   task automatic settle();
      rsp_t r;
      logic [5:0] s;
      int idx;
      bit exp_upd;
      #1;
      chk("rsp_valid", bus.fill_rsp_valid, rsp_due);
      if (bus.fill_rsp_valid && exp_rsp_q.size() > 0) begin
         r = exp_rsp_q.pop_front();
         chk("rsp_set", bus.fill_rsp_set, r.set);
         chk("rsp_way", bus.fill_rsp_way, r.way);
      end
      rsp_due = 0;

      exp_upd = prev_gnt && bus.access_hit_en[prev_idx];
      chk("upd_en", bus.lru_access_update_en, exp_upd);
      if (exp_upd) chk("upd_way", bus.lru_access_update_way, bus.access_hit_way[prev_idx]);
      prev_gnt = 0;

      chk("excl", bus.lru_fill_en && bus.lru_access_en, 0);
      chk("ready", bus.fill_req_ready, occ < DEPTH);
      if (!bus.fill_req_ready) saw_full = 1;

      if (bus.lru_fill_en) begin
         if (exp_issue_q.size() == 0) begin
            chk("fill_unexpected", 1, 0);
         end else begin
            s = exp_issue_q.pop_front();
            chk("fill_set", bus.lru_fill_set, s);
            exp_rsp_q.push_back({s, way_of(s)});
            rsp_due = 1;
         end
         occ--;
         if (|bus.access_req) fill_run++;
      end

      if (|bus.access_grant) begin
         idx = 0;
         for (int i = 0; i < REQS; i++) if (bus.access_grant[i]) idx = i;
         chk("gnt_onehot", $onehot(bus.access_grant), 1);
         chk("gnt_in_req", |(bus.access_grant & ~bus.access_req), 0);
         chk("acc_en", bus.lru_access_en, 1);
         if (exp_gnt_q.size() > 0) chk("gnt_idx", idx, exp_gnt_q.pop_front());
         chk("acc_set", bus.lru_access_set, bus.access_req_set[idx]);
         if (starve_mode) chk("starve_run", fill_run, LIMIT);
         fill_run = 0; prev_gnt = 1; prev_idx = idx; grants_seen++;
      end else begin
         chk("acc_en_idle", bus.lru_access_en, 0);
         if (!(|bus.access_req)) fill_run = 0;
      end

      if (bus.fill_req_valid && bus.fill_req_ready) begin
         exp_issue_q.push_back(bus.fill_req_set);
         occ++;
      end
   endtask

   task automatic adv();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic tick();
      settle();
      adv();
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle_inputs();
      reset = 1'b1;
      flush_model();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_ready", bus.fill_req_ready, 1);
      chk("rst_rsp", bus.fill_rsp_valid, 0);
      chk("rst_fill_en", bus.lru_fill_en, 0);
      chk("rst_acc_en", bus.lru_access_en, 0);
      chk("rst_upd", bus.lru_access_update_en, 0);
      chk("rst_grant", bus.access_grant, 0);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      idle_inputs();
      starve_mode = 0; saw_full = 0; grants_seen = 0;
      flush_model();

      // Single fill: set 5 accepted at T, issued T+1, response T+2 with way 2.
      do_reset();
      bus.fill_req_valid = 1'b1; bus.fill_req_set = 6'd5;
      tick();
      bus.fill_req_valid = 1'b0;
      settle();
      chk("t1_fill_en", bus.lru_fill_en, 1);
      chk("t1_fill_set", bus.lru_fill_set, 5);
      adv();
      settle();
      chk("t1_rsp_valid", bus.fill_rsp_valid, 1);
      chk("t1_rsp_set", bus.fill_rsp_set, 5);
      chk("t1_rsp_way", bus.fill_rsp_way, 2);
      adv();
      tick();

      // Requesters 0 and 2 alternate; hit from 0 forwarded, stray hit ignored.
      do_reset();
      bus.access_req = 4'b0101;
      bus.access_req_set[0] = 6'd3;
      bus.access_req_set[2] = 6'd9;
      exp_gnt_q.push_back(0); exp_gnt_q.push_back(2);
      exp_gnt_q.push_back(0); exp_gnt_q.push_back(2);
      tick();
      bus.access_hit_en = 4'b0001; bus.access_hit_way[0] = 2'd1;
      settle();
      chk("t2_upd_en", bus.lru_access_update_en, 1);
      chk("t2_upd_way", bus.lru_access_update_way, 1);
      adv();
      settle();
      chk("t2_nongranted_hit", bus.lru_access_update_en, 0);
      adv();
      bus.access_hit_en = '0;
      tick();
      chk("t2_all_grants", exp_gnt_q.size(), 0);

      // Requester 3 granted, next cycle only requester 0 reports a hit: no update.
      do_reset();
      bus.access_req = 4'b1000; bus.access_req_set[3] = 6'd12;
      exp_gnt_q.push_back(3);
      tick();
      bus.access_req = '0;
      bus.access_hit_en = 4'b0001; bus.access_hit_way[0] = 2'd3;
      settle();
      chk("t5_no_upd", bus.lru_access_update_en, 0);
      adv();
      bus.access_hit_en = '0;
      tick();

      // Continuous fills with requester 1 waiting: exactly LIMIT fills per grant; FIFO fills up.
      do_reset();
      grants_seen = 0; saw_full = 0;
      bus.fill_req_valid = 1'b1; bus.fill_req_set = 6'd40;
      tick();
      bus.access_req = 4'b0010; bus.access_req_set[1] = 6'd21;
      starve_mode = 1;
      for (int i = 0; i < 45; i++) begin
         bus.fill_req_set = 6'(i);
         tick();
      end
      starve_mode = 0;
      bus.fill_req_valid = 1'b0;
      bus.access_req = '0;
      for (int i = 0; i < 10; i++) tick();
      chk("t4_grants", grants_seen >= 4, 1);
      chk("t4_saw_full", saw_full, 1);
      chk("t4_drained", exp_issue_q.size(), 0);
      chk("t4_rsp_drained", exp_rsp_q.size(), 0);

      // Reset with fills queued and a response pending: everything dropped.
      do_reset();
      for (int i = 0; i < 3; i++) begin
         bus.fill_req_valid = 1'b1; bus.fill_req_set = 6'(10 + i);
         tick();
      end
      bus.fill_req_valid = 1'b0;
      reset = 1'b1;
      #1;
      chk("t6_rsp_suppressed", bus.fill_rsp_valid, 0);
      chk("t6_fill_en", bus.lru_fill_en, 0);
      chk("t6_ready", bus.fill_req_ready, 1);
      @(negedge clk);
      reset = 1'b0;
      flush_model();
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("t6_fifo_empty", bus.lru_fill_en, 0);
         adv();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
